i2c_byte_sequencer: RTL

//  Parametrised byte/ACK phase sequencer for the I2C slave front end, driven by the edge/start/stop detectors.

---
 rtl/i2c_pkg.sv | 15 +
 rtl/flex_counter.sv | 35 +++
 rtl/i2c_byte_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C slave front end.
package i2c_pkg;

  localparam int I2C_DEFAULT_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    ACK_PREP  = 3'd2,
    ACK_CHECK = 3'd3,
    ACK_DONE  = 3'd4,
    HALT      = 3'd5
  } seq_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear (priority over enable) and async active-low reset.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear_i,
  input  logic                    count_enable_i,
  output logic [NUM_CNT_BITS-1:0] count_o
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  // NOTE: default assignment first so every path drives count_d; no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/i2c_byte_sequencer.sv
// Byte/ACK phase sequencer for the I2C slave: counts SCL edges per word, frames the
// ACK slot, counts bytes per transaction and halts on a master NACK in transmit mode.
module i2c_byte_sequencer
  import i2c_pkg::*;
#(
  parameter int DATA_BITS  = I2C_DEFAULT_DATA_BITS,
  parameter int BYTE_CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  rising_edge_found,
  input  logic                  falling_edge_found,
  input  logic                  start_found,
  input  logic                  stop_found,
  input  logic                  mode_tx,
  input  logic                  sda_sync,
  output logic                  shift_strobe,
  output logic                  byte_received,
  output logic                  ack_prep,
  output logic                  check_ack,
  output logic                  ack_done,
  output logic                  nack_seen,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic                  busy
);

  localparam int                CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);

  seq_state_t            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt;
  logic [BYTE_CNT_W-1:0] byte_count_q, byte_count_d;
  logic                  nack_q, nack_d;
  logic                  first_q, first_d;
  logic                  fall_only;
  logic                  rise_in_data;
  logic                  enter_prep;

  // A rising edge in the same cycle swallows the falling edge.
  assign fall_only    = falling_edge_found & ~rising_edge_found;
  assign rise_in_data = (state_q == DATA) & rising_edge_found;
  assign enter_prep   = (state_d == ACK_PREP) & (state_q != ACK_PREP);

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_bit_cnt (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear_i        (start_found | enter_prep),
    .count_enable_i (rise_in_data),
    .count_o        (bit_cnt)
  );

  always_comb begin
    state_d = state_q;
    if (stop_found) begin
      state_d = IDLE;
    end else if (start_found) begin
      state_d = DATA;
    end else begin
      case (state_q)
        DATA:      if (rising_edge_found && bit_cnt == LAST_BIT) state_d = ACK_PREP;
        ACK_PREP:  if (rising_edge_found) state_d = ACK_CHECK;
        ACK_CHECK: if (fall_only) state_d = ACK_DONE;
        ACK_DONE:  state_d = (mode_tx && nack_q) ? HALT : DATA;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    byte_count_d = byte_count_q;
    nack_d       = nack_q;
    first_d      = enter_prep;
    if (!stop_found && start_found) begin
      byte_count_d = '0;
    end else if (state_q == ACK_DONE && byte_count_q != '1) begin
      byte_count_d = byte_count_q + 1'b1;
    end
    if (!stop_found && !start_found && state_q == ACK_PREP && rising_edge_found) begin
      nack_d = sda_sync;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      byte_count_q <= '0;
      nack_q       <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      nack_q       <= nack_d;
      first_q      <= first_d;
    end
  end

  always_comb begin
    shift_strobe  = rise_in_data;
    byte_received = (state_q == ACK_PREP) & first_q;
    ack_prep      = (state_q == ACK_PREP) & fall_only;
    check_ack     = (state_q == ACK_CHECK);
    ack_done      = (state_q == ACK_DONE);
    nack_seen     = (state_q == ACK_DONE) & mode_tx & nack_q;
    busy          = (state_q != IDLE);
  end

  assign byte_count = byte_count_q;

endmodule
